// File: rtl/demux_pkg.sv
// Shared constants, state encoding and the saturating counter helper for the
// 1-to-8 demux dispatcher.
package demux_pkg;

    localparam int NCH        = 8;
    localparam int SELW       = 3;
    localparam int DROP_CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        logic [DROP_CNT_W-1:0] r;
        if (v == {DROP_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/demux_onehot.sv
// Enable-gated 3-to-8 decoder; turns the held destination into the one-hot
// out_valid vector.
module demux_onehot
    import demux_pkg::*;
(
    input  logic            en_i,
    input  logic [SELW-1:0] sel_i,
    output logic [NCH-1:0]  onehot_o
);

    // Decode the destination only while a word is held.
    always_comb begin
        onehot_o = {NCH{1'b0}};
        if (en_i) begin
            onehot_o = {{(NCH-1){1'b0}}, 1'b1} << sel_i;
        end else begin
            onehot_o = {NCH{1'b0}};
        end
    end

endmodule

// File: rtl/demux_dispatch.sv
// Single-entry flow-controlled 1-to-8 dispatcher with stall timeout and drop
// counting. Define DEMUX_RR_EN to replace in_sel with a round-robin pointer.
module demux_dispatch
    import demux_pkg::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    input  logic [SELW-1:0]       in_sel,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    output logic [DW-1:0]         out_data,
    output logic                  busy,
    output logic                  drop,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int WCW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = (TIMEOUT == 0) ? {WCW{1'b0}} : WCW'(TIMEOUT - 1);
    localparam logic           TO_EN     = (TIMEOUT != 0);

    state_e                  state_q, state_d;
    logic [DW-1:0]           data_q, data_d;
    logic [SELW-1:0]         sel_q, sel_d;
    logic [WCW-1:0]          wait_cnt_q, wait_cnt_d;
    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic                    hold_s;
    logic                    dest_ready_s;
    logic                    capture_s;
    logic                    timeout_s;
    logic [SELW-1:0]         dest_s;

`ifdef DEMUX_RR_EN
    logic [SELW-1:0]         rr_ptr_q, rr_ptr_d;

    assign dest_s = rr_ptr_q;

    // Pointer advances at capture, so a later drop still consumes its slot.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (capture_s) begin
            rr_ptr_d = rr_ptr_q + {{(SELW-1){1'b0}}, 1'b1};
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= {SELW{1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign dest_s = in_sel;
`endif

    assign hold_s       = (state_q == HOLD);
    assign dest_ready_s = out_ready[sel_q];
    // in_ready is forced low during reset so nothing looks acceptable then.
    assign in_ready     = ~rst & (~hold_s | dest_ready_s);
    assign capture_s    = in_ready & in_valid;
    assign timeout_s    = TO_EN & hold_s & ~dest_ready_s & (wait_cnt_q == WAIT_LAST);

    assign out_data = data_q;
    assign busy     = hold_s;
    assign drop     = timeout_s;
    assign drop_cnt = drop_cnt_q;

    demux_onehot u_onehot (
        .en_i     (hold_s),
        .sel_i    (sel_q),
        .onehot_o (out_valid)
    );

    // Next-state: completion and capture first, then stall/timeout handling.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sel_d      = sel_q;
        wait_cnt_d = wait_cnt_q;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            IDLE: begin
                if (capture_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (dest_ready_s) begin
                    state_d = capture_s ? HOLD : IDLE;
                end else if (timeout_s) begin
                    state_d    = IDLE;
                    drop_cnt_d = sat_inc(drop_cnt_q);
                end else begin
                    state_d    = HOLD;
                    wait_cnt_d = wait_cnt_q + {{(WCW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture_s) begin
            data_d     = in_data;
            sel_d      = dest_s;
            wait_cnt_d = {WCW{1'b0}};
        end else begin
            data_d = data_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= {DW{1'b0}};
            sel_q      <= {SELW{1'b0}};
            wait_cnt_q <= {WCW{1'b0}};
            drop_cnt_q <= {DROP_CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            wait_cnt_q <= wait_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: doc/demux_dispatch.md
# demux_dispatch

Sequential controller for the 1-to-8 demultiplexer datapath: accepts data words on a valid/ready input stream, holds each word in a single-entry register, and steers it to one of eight output channels with per-channel valid/ready handshakes. Words whose destination stalls for too long are dropped, flagged, and counted. It sits between a single producer and eight consumer channels, replacing free-running select lines with a flow-controlled dispatch.

## Interface
- DW, 8: data word width
- TIMEOUT, 15: HOLD cycles without destination ready before drop; 0 disables the timeout (wait forever)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts word this cycle
- in_data  in  DW  word
- in_sel  in  3  destination channel 0..7
- out_valid  out  8  one-hot, at most one bit set
- out_ready  in  8  per-channel consumer ready
- out_data  out  DW  held word, shared by all channels
- busy  out  1  1 in HOLD
- drop  out  1  one-cycle pulse when a word is discarded
- drop_cnt  out  8  saturating count of dropped words

## Operation
- States: IDLE (register empty), HOLD (register full).
- IDLE: in_ready=1. On in_valid: capture in_data into data_q, destination into sel_q, clear wait_cnt, go to HOLD.
- HOLD: out_valid[sel_q]=1, all other out_valid bits 0, out_data=data_q, busy=1.
  - If out_ready[sel_q]=1, the transfer completes this cycle.
  - in_ready = out_ready[sel_q]. If in_valid is also high, the new word is captured in the same cycle and the block stays in HOLD (back-to-back, one word per cycle). Otherwise it goes to IDLE.
  - Readiness on any channel other than sel_q is ignored.
  - If not ready: wait_cnt increments. When TIMEOUT!=0 and wait_cnt==TIMEOUT-1 with ready still low:
    - drop=1 for one cycle, drop_cnt increments (saturating at 255), go to IDLE.
    - in_ready stays 0 in the drop cycle.
- wait_cnt width is $clog2(TIMEOUT+1), minimum 1. It clears on every capture.
- out_data holds its last value in IDLE. Consumers must qualify it with out_valid.
- Reset values while rst=1: state=IDLE, in_ready=0, out_valid=0, out_data=0, busy=0, drop=0, drop_cnt=0, wait_cnt=0. An in-flight word is discarded without a drop pulse.

## Timing
- Latency: a word accepted at edge N appears on out_valid/out_data in the cycle after edge N. Minimum latency 1 cycle.
- Throughput: 1 word/cycle while the destination holds out_ready high.
- Drop: with out_ready held low, a word captured at edge N is dropped at edge N+TIMEOUT. drop is high in the cycle before that edge.
- in_ready and out_valid are combinational from state, sel_q and out_ready; there is no combinational path from in_valid.
- Simultaneous complete and capture at the same edge: the new word wins, and no IDLE bubble occurs.
- A timeout coinciding with ready rising in the same cycle counts as a completion, not a drop.

## Configuration
- DEMUX_RR_EN defined:
  - in_sel is ignored. Destination is an internal 3-bit pointer rr_ptr (reset 0).
  - rr_ptr increments on every capture and wraps 7->0.
  - A dropped word still advances the pointer, because the pointer advanced at capture.
- DEMUX_RR_EN undefined: destination = in_sel sampled at capture, and rr_ptr does not exist.

## Structure
- Package demux_pkg:
  - NCH=8, SELW=3
  - state enum {IDLE, HOLD}
  - DROP_CNT_W=8
- Sub-module demux_onehot: a combinational 3-to-8 decoder gated by an enable. It produces out_valid from sel_q and (state==HOLD), mirroring the gate-level demux structure.
- Everything else lives in demux_dispatch.

## Test plan
- Addressed single word: in_sel=5, in_data=0xA5, out_ready=0xFF -> out_valid=0x20 with out_data=0xA5 for exactly one cycle, then IDLE.
- Back-to-back burst: 8 words with sel 0..7, all ready -> 8 consecutive cycles, out_valid 0x01,0x02,…,0x80, in_ready constantly 1.
- Stall and timeout (TIMEOUT=15): sel=3, out_ready=0xF7 -> out_valid=0x08 held 15 cycles, drop pulse once, drop_cnt=1, unrelated ready bits ignored. Repeat 300 drops -> drop_cnt saturates at 255.
- Late ready: sel=2, out_ready[2] rises in the cycle where wait_cnt==TIMEOUT-1 -> transfer completes, drop=0, drop_cnt unchanged.
- Reset mid-HOLD: assert rst asynchronously while out_valid=0x10 -> all outputs 0 immediately, no drop pulse; after release in_ready=1.
- DEMUX_RR_EN: 10 words with in_sel fixed at 6 -> destinations 0,1,…,7,0,1; drop the 3rd word -> the 4th still goes to channel 3.
